// File: rtl/ece429_srec_loader.sv
// rtl/ece429_srec_loader.sv - binary S-record style loader: parses framed byte stream into word writes.
// Optional checksum comparison enabled by defining ECE429_LOADER_CHKSUM_EN.
module ece429_srec_loader (
    input  logic        clock,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        stall,
    output logic [31:0] parse_addr,
    output logic [31:0] parse_data,
    output logic [1:0]  parse_access_size,
    output logic [31:0] max_fetch_addr,
    output logic [31:0] start_addr,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_TYPE = 3'd0,
        S_LEN  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] TYPE_DATA = 8'h01;
    localparam logic [7:0] TYPE_END  = 8'h09;

    state_t      state_q, state_d;
    logic        is_end_q, is_end_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  sum_q, sum_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] rec_addr_q, rec_addr_d;
    logic [31:0] word_addr_q, word_addr_d;
    logic [31:0] parse_addr_q, parse_addr_d;
    logic [31:0] parse_data_q, parse_data_d;
    logic [31:0] max_q, max_d;
    logic [31:0] start_q, start_d;

    logic        xfer;
    logic        csum_ok;
    logic [31:0] addr_full;

    assign xfer      = rx_valid && rx_ready;
    assign addr_full = {rec_addr_q[23:0], rx_data};

`ifdef ECE429_LOADER_CHKSUM_EN
    assign csum_ok = (rx_data == ~sum_q);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_TYPE;
            is_end_q     <= 1'b0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            sum_q        <= 8'd0;
            asm_q        <= 24'd0;
            rec_addr_q   <= 32'd0;
            word_addr_q  <= 32'd0;
            parse_addr_q <= 32'd0;
            parse_data_q <= 32'd0;
            max_q        <= 32'd0;
            start_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            is_end_q     <= is_end_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            asm_q        <= asm_d;
            rec_addr_q   <= rec_addr_d;
            word_addr_q  <= word_addr_d;
            parse_addr_q <= parse_addr_d;
            parse_data_q <= parse_data_d;
            max_q        <= max_d;
            start_q      <= start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_end_d     = is_end_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        asm_d        = asm_q;
        rec_addr_d   = rec_addr_q;
        word_addr_d  = word_addr_q;
        parse_addr_d = parse_addr_q;
        parse_data_d = parse_data_q;
        max_d        = max_q;
        start_d      = start_q;
        if (xfer) begin
            case (state_q)
                S_TYPE: begin
                    sum_d = 8'd0;
                    cnt_d = 8'd0;
                    if (rx_data == TYPE_DATA) begin
                        is_end_d = 1'b0;
                        state_d  = S_LEN;
                    end else if (rx_data == TYPE_END) begin
                        is_end_d = 1'b1;
                        state_d  = S_LEN;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_LEN: begin
                    len_d = rx_data;
                    sum_d = rx_data;
                    cnt_d = 8'd0;
                    if (is_end_q ? (rx_data != 8'd0)
                                 : ((rx_data == 8'd0) || (rx_data[1:0] != 2'b00))) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    rec_addr_d = addr_full;
                    sum_d      = sum_q + rx_data;
                    if (cnt_q == 8'd3) begin
                        cnt_d = 8'd0;
                        if (rx_data[1:0] != 2'b00) begin
                            state_d = S_ERR;
                        end else begin
                            word_addr_d = addr_full;
                            state_d     = is_end_q ? S_CSUM : S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_DATA: begin
                    asm_d = {asm_q[15:0], rx_data};
                    sum_d = sum_q + rx_data;
                    // Fourth byte of a word: publish it and advance the write pointer.
                    if (cnt_q[1:0] == 2'b11) begin
                        parse_data_d = {asm_q, rx_data};
                        parse_addr_d = word_addr_q;
                        word_addr_d  = word_addr_q + 32'd4;
                        if (word_addr_q > max_q) begin
                            max_d = word_addr_q;
                        end
                    end
                    if (cnt_q == (len_q - 8'd1)) begin
                        cnt_d   = 8'd0;
                        state_d = S_CSUM;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_CSUM: begin
                    if (!csum_ok) begin
                        state_d = S_ERR;
                    end else if (is_end_q) begin
                        start_d = rec_addr_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TYPE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        rx_ready = 1'b0;
        stall    = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_TYPE, S_LEN, S_ADDR, S_DATA, S_CSUM: rx_ready = 1'b1;
            S_DONE: begin
                stall = 1'b0;
                done  = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

    assign parse_addr        = parse_addr_q;
    assign parse_data        = parse_data_q;
    assign parse_access_size = 2'b00;
    assign max_fetch_addr    = max_q;
    assign start_addr        = start_q;

endmodule

// File: tb/tb_ece429_srec_loader.sv
// tb/tb_ece429_srec_loader.sv - directed bench with write scoreboard for ece429_srec_loader.
module tb_ece429_srec_loader;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        stall;
    logic [31:0] parse_addr;
    logic [31:0] parse_data;
    logic [1:0]  parse_access_size;
    logic [31:0] max_fetch_addr;
    logic [31:0] start_addr;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_data = 32'd0;
    logic [7:0]  d[8];

    ece429_srec_loader dut (
        .clock(clock),
        .resetn(resetn),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .stall(stall),
        .parse_addr(parse_addr),
        .parse_data(parse_data),
        .parse_access_size(parse_access_size),
        .max_fetch_addr(max_fetch_addr),
        .start_addr(start_addr),
        .done(done),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Every change of the write port is one word write; it must match the oldest expectation.
    always @(negedge clock) begin
        if (!resetn) begin
            prev_addr <= parse_addr;
            prev_data <= parse_data;
        end else if (parse_addr !== prev_addr || parse_data !== prev_data) begin
            prev_addr <= parse_addr;
            prev_data <= parse_data;
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", parse_addr, 32'hDEADBEEF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", parse_addr, e[63:32]);
                check("write_data", parse_data, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        rx_valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] pending);
        @(negedge clock);
        rx_data  = pending;
        rx_valid = 1'b1;
        resetn   = 1'b0;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic send_rec(input logic [7:0] typ, input logic [31:0] addr, input int n,
                            input logic [7:0] xr, input bit gaps);
        logic [7:0] sum;
        logic [7:0] len;
        len = n[7:0];
        sum = len + addr[31:24] + addr[23:16] + addr[15:8] + addr[7:0];
        send_byte(typ);
        if (gaps) idle_cycle();
        send_byte(len);
        for (int i = 3; i >= 0; i--) begin
            if (gaps) idle_cycle();
            send_byte(addr[i*8 +: 8]);
        end
        for (int i = 0; i < n; i++) begin
            sum = sum + d[i];
            if (gaps) idle_cycle();
            send_byte(d[i]);
            if (i % 4 == 3) begin
                exp_q.push_back({addr + 32'(4 * (i / 4)), d[i-3], d[i-2], d[i-1], d[i]});
            end
        end
        if (gaps) idle_cycle();
        send_byte((~sum) ^ xr);
    endtask

    initial begin
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        d[4] = 8'hAA; d[5] = 8'hBB; d[6] = 8'hCC; d[7] = 8'hDD;

        // Reset takes priority over a concurrent bad type byte.
        do_reset(8'h05);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_parse_addr", parse_addr, 32'd0);
        check("rst_parse_data", parse_data, 32'd0);
        check("rst_max", max_fetch_addr, 32'd0);
        check("rst_start", start_addr, 32'd0);
        check("access_size", {30'd0, parse_access_size}, 32'd0);

        send_rec(8'h01, 32'h0000_0100, 8, 8'h00, 1'b0);
        idle_cycle();
        check("rec1_max", max_fetch_addr, 32'h104);
        check("rec1_stall", {31'd0, stall}, 32'd1);
        check("rec1_ready", {31'd0, rx_ready}, 32'd1);
        check("rec1_pending", exp_q.size(), 32'd0);

        send_rec(8'h09, 32'h0000_0100, 0, 8'h00, 1'b0);
        check("end_done", {31'd0, done}, 32'd1);
        check("end_stall", {31'd0, stall}, 32'd0);
        check("end_start", start_addr, 32'h100);
        check("end_ready", {31'd0, rx_ready}, 32'd0);
        check("end_err", {31'd0, err}, 32'd0);

        // Paced stream into a fresh load.
        do_reset(8'h00);
        send_rec(8'h01, 32'h0000_0300, 8, 8'h00, 1'b1);
        idle_cycle();
        check("gap_max", max_fetch_addr, 32'h304);
        check("gap_pending", exp_q.size(), 32'd0);

        // Wrap-around of the word pointer: max stays at the top word.
        send_rec(8'h01, 32'hFFFF_FFFC, 8, 8'h00, 1'b0);
        idle_cycle();
        check("wrap_max", max_fetch_addr, 32'hFFFF_FFFC);
        check("wrap_last_addr", parse_addr, 32'h0);

        do_reset(8'h00);
        send_rec(8'h01, 32'h0000_0500, 8, 8'h01, 1'b0);
        idle_cycle();
        check("badsum_pending", exp_q.size(), 32'd0);
        check("badsum_max", max_fetch_addr, 32'h504);
`ifdef ECE429_LOADER_CHKSUM_EN
        check("badsum_err", {31'd0, err}, 32'd1);
        check("badsum_stall", {31'd0, stall}, 32'd1);
        check("badsum_ready", {31'd0, rx_ready}, 32'd0);
`else
        check("badsum_err", {31'd0, err}, 32'd0);
        check("badsum_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h05);
        check("badsum_back_in_type", {31'd0, err}, 32'd1);
`endif

        do_reset(8'h00);
        send_byte(8'h05);
        check("bad_type_err", {31'd0, err}, 32'd1);
        check("bad_type_ready", {31'd0, rx_ready}, 32'd0);
        check("bad_type_done", {31'd0, done}, 32'd0);

        do_reset(8'h00);
        send_byte(8'h01);
        check("len_pre_err", {31'd0, err}, 32'd0);
        send_byte(8'h06);
        check("bad_len_err", {31'd0, err}, 32'd1);

        do_reset(8'h00);
        send_byte(8'h01);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        check("addr_pre_err", {31'd0, err}, 32'd0);
        send_byte(8'h02);
        check("bad_addr_err", {31'd0, err}, 32'd1);
        check("bad_addr_stall", {31'd0, stall}, 32'd1);

        // Partial word discarded by reset, then a clean record.
        do_reset(8'h00);
        send_byte(8'h01);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h77);
        send_byte(8'h66);
        do_reset(8'h00);
        check("partial_ready", {31'd0, rx_ready}, 32'd1);
        send_rec(8'h01, 32'h0000_0200, 8, 8'h00, 1'b0);
        idle_cycle();
        check("partial_max", max_fetch_addr, 32'h204);
        check("partial_pending", exp_q.size(), 32'd0);
        check("partial_err", {31'd0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ece429_srec_loader.md
ECE429_SREC_LOADER -- requirements
Module: ece429_srec_loader

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge system clock; the one clock; reset is synchronous and active-low.
REQ-002 SHALL have ports: resetn  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: rx_data  in  8  incoming load-stream byte; rx_valid  in  1  byte present; rx_ready  out  1  byte accepted this edge when high with rx_valid.
REQ-004 SHALL have ports: stall  out  1  holds CPU and selects the parse_* memory-write path.
REQ-005 SHALL have ports: parse_addr  out  32  word write address; parse_data  out  32  word write data (big-endian); parse_access_size  out  2  constant 2'b00 (single word).
REQ-006 SHALL have ports: max_fetch_addr  out  32  highest word address written; start_addr  out  32  entry address from end record; done  out  1  load complete; err  out  1  sticky load error.

Function
REQ-007 Frame format SHALL be: type byte (0x01 data, 0x09 end), length byte N, 4 address bytes MSB-first, N data bytes (data records only; N=0 for end), checksum byte.
REQ-008 Checksum SHALL equal bitwise NOT of the low 8 bits of sum(length, 4 address bytes, data bytes).
REQ-009 A byte SHALL transfer only on a rising edge with rx_valid=1 and rx_ready=1; rx_ready SHALL be 1 in every parse state and 0 in DONE and ERR.
REQ-010 FSM states SHALL be TYPE, LEN, ADDR, DATA, CSUM, DONE, ERR; ADDR and DATA use a byte counter.
REQ-011 TYPE: 0x01 or 0x09 -> LEN; any other value -> ERR.
REQ-012 LEN: data record with N=0 or N[1:0]!=0 -> ERR; end record with N!=0 -> ERR; else -> ADDR.
REQ-013 ADDR: after 4th byte, address[1:0]!=0 -> ERR; else data record -> DATA, end record -> CSUM.
REQ-014 DATA: bytes SHALL shift into a 32-bit assembly register MSB-first; on every 4th byte parse_data and parse_addr SHALL update at that same edge, 1-cycle latency from acceptance to output.
REQ-015 Word address SHALL start at the record address and increment by 4 per word, wrapping modulo 2^32.
REQ-016 parse_addr/parse_data SHALL change only on word completion; between completions they hold, so repeated writes by the memory are idempotent.
REQ-017 On word completion, max_fetch_addr SHALL update to the written address if greater (unsigned).
REQ-018 After the Nth data byte -> CSUM; CSUM match -> data record TYPE, end record DONE with start_addr = record address; mismatch -> ERR.
REQ-019 Words of a record failing checksum SHALL already be written; no rollback.
REQ-020 DONE: stall=0, done=1, all outputs hold until reset.
REQ-021 ERR: stall=1, err=1, done=0, all other outputs hold until reset.
REQ-022 rx_valid low mid-frame SHALL pause the FSM with no timeout; state and counters hold.

Reset
REQ-023 On resetn=0 at a rising edge: state=TYPE, stall=1, parse_addr=0, parse_data=0, max_fetch_addr=0, start_addr=0, done=0, err=0, counters and checksum accumulator=0.
REQ-024 Reset mid-frame SHALL discard the partial word and frame; rx_ready SHALL be 1 from the first edge after reset deasserts.
REQ-025 Reset SHALL take priority over a simultaneous byte transfer.

Configuration
REQ-026 Macro ECE429_LOADER_CHKSUM_EN defined: REQ-008/REQ-018 checksum comparison active.
REQ-027 Macro undefined: checksum byte consumed and ignored, CSUM always treated as match, mismatch never causes ERR; structural errors (REQ-011..013) still apply.

Verification
REQ-028 Data record addr 0x00000100, N=8, data 11 22 33 44 AA BB CC DD, valid checksum -> parse 0x100/0x11223344 then 0x104/0xAABBCCDD; max_fetch_addr=0x104; stall=1.
REQ-029 That record followed by end record addr 0x00000100, valid checksum -> done=1, stall=0, start_addr=0x100, rx_ready=0.
REQ-030 Data record with checksum XOR 0x01, macro defined -> words written, err=1, stall=1, rx_ready=0; macro undefined -> no error, FSM returns to TYPE.
REQ-031 Type byte 0x05, or N=6, or address 0x00000102 -> err=1 at the offending byte's edge.
REQ-032 Data record with rx_valid toggling every other cycle -> identical outputs to back-to-back stream, delayed only.
REQ-033 resetn=0 after 2 data bytes of a word, then a full valid record at 0x200 -> no write from partial word; first write 0x200; max_fetch_addr reflects only new record.
